// File: rtl/mul8_loop_ctrl.sv
// ============================================================================
// Module   : mul8_loop_ctrl
// Brief    : Issue/collect controller for the mul8_loop sequential multiplier.
//            Operand-pair FIFO, start/busy sequencing, result hold, timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mul8_loop_ctrl #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DW-1:0]                 in_a,
    input  logic [DW-1:0]                 in_b,
    output logic                          mul_start,
    output logic [DW-1:0]                 mul_a,
    output logic [DW-1:0]                 mul_b,
    input  logic                          mul_busy,
    input  logic [DW-1:0]                 mul_p,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DW-1:0]                 out_p,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_timeout
);

    localparam int c_AW      = $clog2(FIFO_DEPTH);
    localparam int c_LW      = c_AW + 1;
    localparam int c_CW      = $clog2(TIMEOUT + 1);
    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              r_state_q,     w_state_d;
    logic [c_AW-1:0]     r_wr_ptr_q,    w_wr_ptr_d;
    logic [c_AW-1:0]     r_rd_ptr_q,    w_rd_ptr_d;
    logic [c_LW-1:0]     r_level_q,     w_level_d;
    logic [DW-1:0]       r_mul_a_q,     w_mul_a_d;
    logic [DW-1:0]       r_mul_b_q,     w_mul_b_d;
    logic                r_out_valid_q, w_out_valid_d;
    logic [DW-1:0]       r_out_p_q,     w_out_p_d;
    logic                r_err_q,       w_err_d;
    logic [c_CW-1:0]     r_wait_cnt_q,  w_wait_cnt_d;

    logic [DW-1:0]       r_fifo_a_q [FIFO_DEPTH];
    logic [DW-1:0]       r_fifo_b_q [FIFO_DEPTH];

    logic                w_full;
    logic                w_push;
    logic                w_pop;

    // in_ready looks only at the registered level, so a same-cycle pop
    // never opens the input port early.
    assign w_full      = (r_level_q == c_LW'(FIFO_DEPTH));
    assign w_push      = in_valid & ~w_full;

    assign in_ready    = ~w_full;
    assign mul_start   = (r_state_q == S_ISSUE);
    assign mul_a       = r_mul_a_q;
    assign mul_b       = r_mul_b_q;
    assign out_valid   = r_out_valid_q;
    assign out_p       = r_out_p_q;
    assign fifo_level  = r_level_q;
    assign err_timeout = r_err_q;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a_q[r_wr_ptr_q] <= in_a;
            r_fifo_b_q[r_wr_ptr_q] <= in_b;
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_mul_a_d     = r_mul_a_q;
        w_mul_b_d     = r_mul_b_q;
        w_out_valid_d = r_out_valid_q;
        w_out_p_d     = r_out_p_q;
        w_err_d       = r_err_q;
        w_wait_cnt_d  = r_wait_cnt_q;
        w_pop         = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (r_level_q != '0) begin
                    w_mul_a_d = r_fifo_a_q[r_rd_ptr_q];
                    w_mul_b_d = r_fifo_b_q[r_rd_ptr_q];
                    w_pop     = 1'b1;
                    w_state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_wait_cnt_d = '0;
                w_state_d    = S_WAIT;
            end
            S_WAIT: begin
                w_wait_cnt_d = r_wait_cnt_q + c_CW'(1);
                // Completion wins over a timeout detected in the same cycle.
                if (!mul_busy) begin
                    w_out_p_d     = mul_p;
                    w_out_valid_d = 1'b1;
                    w_state_d     = S_HOLD;
                end else if (r_wait_cnt_q == c_CW'(TIMEOUT - 1)) begin
                    w_err_d   = 1'b1;
                    w_state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_state_d     = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_AW'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   w_level_d = r_level_q + c_LW'(1);
            2'b01:   w_level_d = r_level_q - c_LW'(1);
            default: w_level_d = r_level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_level_q     <= '0;
            r_mul_a_q     <= '0;
            r_mul_b_q     <= '0;
            r_out_valid_q <= 1'b0;
            r_out_p_q     <= '0;
            r_err_q       <= 1'b0;
            r_wait_cnt_q  <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_level_q     <= w_level_d;
            r_mul_a_q     <= w_mul_a_d;
            r_mul_b_q     <= w_mul_b_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_p_q     <= w_out_p_d;
            r_err_q       <= w_err_d;
            r_wait_cnt_q  <= w_wait_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul8_loop_ctrl.sv
// ============================================================================
// Module   : tb_mul8_loop_ctrl
// Brief    : Self-checking bench for mul8_loop_ctrl with a behavioural
//            multiplier model and an in-order result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mul8_loop_ctrl;

    localparam int DW         = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          mul_start;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic          mul_busy;
    logic [DW-1:0] mul_p;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_p;
    logic [2:0]    fifo_level;
    logic          err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    mul8_loop_ctrl #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_busy    (mul_busy),
        .mul_p       (mul_p),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_p       (out_p),
        .fifo_level  (fifo_level),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Multiplier model: busy for 8 cycles after start, garbage product while busy.
    logic [3:0]    m_cnt     = 4'd0;
    logic [DW-1:0] m_prod    = '0;
    logic          m_started = 1'b0;
    logic          stuck     = 1'b0;
    logic          pwr_mode  = 1'b0;

    always @(posedge clk) begin
        if (mul_start) begin
            m_cnt  <= 4'd8;
            m_prod <= mul_a * mul_b;
        end else if (m_cnt != 4'd0) begin
            m_cnt <= m_cnt - 4'd1;
        end
        if (rst)            m_started <= 1'b0;
        else if (mul_start) m_started <= 1'b1;
    end

    assign mul_busy = stuck | (pwr_mode & ~m_started) | (m_cnt != 4'd0);
    assign mul_p    = (m_cnt != 4'd0) ? 8'hA5 : m_prod;

    // Scoreboard
    logic [DW-1:0]   exp_q[$];
    logic [2*DW-1:0] sb_prod;
    logic            sb_err_prev = 1'b0;
    int              n_out = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            sb_err_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                sb_prod = {{DW{1'b0}}, in_a} * {{DW{1'b0}}, in_b};
                exp_q.push_back(sb_prod[DW-1:0]);
            end
            // A timed-out operation never yields a result.
            if (err_timeout && !sb_err_prev && exp_q.size() != 0) void'(exp_q.pop_front());
            sb_err_prev = err_timeout;
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) check_val("sb_unexpected_out", 32'(out_p), 32'hFFFF_FFFF);
                else                   check_val("sb_out_p", 32'(out_p), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        tick();
        check_val("rst_in_ready",   32'(in_ready),    32'd1);
        check_val("rst_level",      32'(fifo_level),  32'd0);
        check_val("rst_mul_start",  32'(mul_start),   32'd0);
        check_val("rst_mul_ab",     32'({mul_a, mul_b}), 32'd0);
        check_val("rst_out_valid",  32'(out_valid),   32'd0);
        check_val("rst_out_p",      32'(out_p),       32'd0);
        check_val("rst_err",        32'(err_timeout), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] t2_a [3];
        logic [DW-1:0] t2_b [3];
        logic [DW-1:0] t2_e [3];
        int accepted;
        int out_base;
        int guard;

        // Single op: 13*11 = 0x8F
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            in_valid = (c == 0); in_a = 8'd13; in_b = 8'd11;
            out_ready = (c == 12);
            check_val("t1_start", 32'(mul_start), 32'(c == 2));
            check_val("t1_valid", 32'(out_valid), 32'(c == 12));
            if (c == 12) check_val("t1_out_p", 32'(out_p), 32'h8F);
            tick();
        end

        // Truncation and zero operands, back to back
        t2_a = '{8'd20, 8'd0,   8'd255};
        t2_b = '{8'd20, 8'd255, 8'd1};
        t2_e = '{8'h90, 8'h00,  8'hFF};
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c <= 38; c++) begin
            in_valid = (c < 3);
            if (c < 3) begin in_a = t2_a[c]; in_b = t2_b[c]; end
            check_val("t2_start", 32'(mul_start), 32'(c == 2 || c == 14 || c == 26));
            check_val("t2_valid", 32'(out_valid), 32'(c == 12 || c == 24 || c == 36));
            if (c == 12 || c == 24 || c == 36) check_val("t2_out_p", 32'(out_p), 32'(t2_e[c/12 - 1]));
            tick();
        end
        in_valid = 1'b0;

        // Backpressure: six (2,3) pairs with out_ready low
        do_reset();
        out_base = n_out;
        accepted = 0;
        in_a = 8'd2; in_b = 8'd3;
        for (int c = 0; c <= 5; c++) begin
            in_valid = 1'b1;
            if (c == 5) begin
                check_val("t3_level_full", 32'(fifo_level), 32'd4);
                check_val("t3_in_ready",   32'(in_ready),   32'd0);
                check_val("t3_accepted",   32'(accepted),   32'd5);
            end
            if (in_valid && in_ready) accepted++;
            tick();
        end
        guard = 0;
        while (!out_valid && guard < 30) begin
            if (in_valid && in_ready) accepted++;
            tick();
            guard++;
        end
        check_val("t3_first_valid", 32'(out_valid), 32'd1);
        check_val("t3_first_p",     32'(out_p),     32'd6);
        for (int s = 0; s < 20; s++) begin
            if (in_valid && in_ready) accepted++;
            tick();
            check_val("t3_stall_valid", 32'(out_valid), 32'd1);
            check_val("t3_stall_p",     32'(out_p),     32'd6);
        end
        out_ready = 1'b1;
        guard = 0;
        while (!(accepted == 6 && exp_q.size() == 0) && guard < 150) begin
            in_valid = (accepted < 6);
            if (in_valid && in_ready) accepted++;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        check_val("t3_drain_done", 32'(guard < 150), 32'd1);
        check_val("t3_results",    32'(n_out - out_base), 32'd6);

        // Timeout with a stuck-busy multiplier
        do_reset();
        stuck = 1'b1;
        for (int c = 0; c <= 22; c++) begin
            in_valid = (c == 0); in_a = 8'd5; in_b = 8'd5;
            check_val("t4_start", 32'(mul_start),   32'(c == 2));
            check_val("t4_valid", 32'(out_valid),   32'd0);
            check_val("t4_err",   32'(err_timeout), 32'(c >= 18));
            tick();
        end
        stuck = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c <= 13; c++) begin
            in_valid = (c == 0); in_a = 8'd4; in_b = 8'd5;
            check_val("t4_post_valid", 32'(out_valid),   32'(c == 12));
            check_val("t4_sticky",     32'(err_timeout), 32'd1);
            if (c == 12) check_val("t4_post_p", 32'(out_p), 32'd20);
            tick();
        end
        do_reset();

        // Reset mid-WAIT
        out_ready = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            in_valid = (c == 0); in_a = 8'd7; in_b = 8'd9;
            rst = (c == 6);
            check_val("t5_start", 32'(mul_start), 32'(c == 2));
            check_val("t5_valid", 32'(out_valid), 32'd0);
            tick();
        end
        rst = 1'b0;
        check_val("t5_out_valid", 32'(out_valid),        32'd0);
        check_val("t5_out_p",     32'(out_p),            32'd0);
        check_val("t5_mul_ab",    32'({mul_a, mul_b}),   32'd0);
        check_val("t5_level",     32'(fifo_level),       32'd0);
        check_val("t5_in_ready",  32'(in_ready),         32'd1);
        for (int k = 0; k <= 13; k++) begin
            in_valid = (k == 0); in_a = 8'd3; in_b = 8'd4;
            check_val("t5_new_start", 32'(mul_start), 32'(k == 2));
            check_val("t5_new_valid", 32'(out_valid), 32'(k == 12));
            if (k == 12) check_val("t5_new_p", 32'(out_p), 32'd12);
            tick();
        end

        // Power-up busy ignored outside WAIT
        pwr_mode = 1'b1;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c <= 13; c++) begin
            in_valid = (c == 0); in_a = 8'd1; in_b = 8'd1;
            check_val("t6_start", 32'(mul_start), 32'(c == 2));
            check_val("t6_valid", 32'(out_valid), 32'(c == 12));
            if (c == 12) check_val("t6_out_p", 32'(out_p), 32'd1);
            tick();
        end
        pwr_mode = 1'b0;
        in_valid = 1'b0;

        tick();
        check_val("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
